// File: rtl/vmem_store_crossbar_128_7_8_32_5_if.sv
// Store request and memory-line beat signals between a vector store unit
// and the data-cache write port.
interface vmem_store_crossbar_128_7_8_32_5_if #(
  parameter int unsigned INWIDTH  = 128,
  parameter int unsigned NUMLANES = 8,
  parameter int unsigned OUTWIDTH = 32,
  parameter int unsigned SELWIDTH = 2
);
  logic                           in_valid;
  logic                           in_ready;
  logic [OUTWIDTH*NUMLANES-1:0]   in_data;
  logic [SELWIDTH*NUMLANES-1:0]   in_sel;
  logic [NUMLANES-1:0]            in_en;
  logic [(OUTWIDTH/8)*NUMLANES-1:0] in_bytemask;
  logic                           out_valid;
  logic                           out_ready;
  logic [INWIDTH-1:0]             out_data;
  logic [INWIDTH/8-1:0]           out_byteen;
  logic                           out_last;

  modport master (
    output in_valid, in_data, in_sel, in_en, in_bytemask, out_ready,
    input  in_ready, out_valid, out_data, out_byteen, out_last
  );

  modport slave (
    input  in_valid, in_data, in_sel, in_en, in_bytemask, out_ready,
    output in_ready, out_valid, out_data, out_byteen, out_last
  );
endinterface

// File: rtl/vmem_store_crossbar_128_7_8_32_5.sv
// Vector store crossbar: steers per-lane store words into memory-line beats,
// serialising lanes that collide on the same word in lane order.
module vmem_store_crossbar_128_7_8_32_5 #(
  parameter int unsigned INWIDTH     = 128,
  parameter int unsigned LOGINWIDTH  = 7,
  parameter int unsigned NUMLANES    = 8,
  parameter int unsigned OUTWIDTH    = 32,
  parameter int unsigned LOGOUTWIDTH = 5
) (
  input logic clk,
  input logic resetn,
  vmem_store_crossbar_128_7_8_32_5_if.slave bus
);
  localparam int unsigned SELWIDTH = LOGINWIDTH - LOGOUTWIDTH;
  localparam int unsigned NUMWORDS = INWIDTH / OUTWIDTH;
  localparam int unsigned BPL      = OUTWIDTH / 8;

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t                        r_state, w_state_nxt;
  logic [OUTWIDTH*NUMLANES-1:0]  r_data, w_src_data;
  logic [SELWIDTH*NUMLANES-1:0]  r_sel, w_src_sel;
  logic [BPL*NUMLANES-1:0]       r_mask, w_src_mask;
  logic [NUMLANES-1:0]           r_pending, w_src_pending, w_chosen, w_rest;
  logic [NUMWORDS-1:0]           w_hit;
  logic [INWIDTH-1:0]            w_beat_data, r_out_data;
  logic [INWIDTH/8-1:0]          w_beat_be, r_out_byteen;
  logic                          r_out_valid, r_out_last;
  logic                          w_in_hs, w_out_hs, w_load;

  assign w_in_hs  = bus.in_valid && (r_state == IDLE);
  assign w_out_hs = r_out_valid && bus.out_ready;

  // In IDLE the first beat is built straight from the request inputs so it
  // can be registered on the acceptance edge; afterwards from latched copies.
  always_comb begin
    if (r_state == IDLE) begin
      w_src_data    = bus.in_data;
      w_src_sel     = bus.in_sel;
      w_src_mask    = bus.in_bytemask;
      w_src_pending = bus.in_en;
    end else begin
      w_src_data    = r_data;
      w_src_sel     = r_sel;
      w_src_mask    = r_mask;
      w_src_pending = r_pending;
    end
  end

  always_comb begin
    w_hit       = '0;
    w_chosen    = '0;
    w_beat_data = '0;
    w_beat_be   = '0;
    for (int unsigned w = 0; w < NUMWORDS; w++) begin
      for (int unsigned i = 0; i < NUMLANES; i++) begin
        if (!w_hit[w] && w_src_pending[i] &&
            (w_src_sel[i*SELWIDTH +: SELWIDTH] == SELWIDTH'(w))) begin
          w_hit[w]                             = 1'b1;
          w_chosen[i]                          = 1'b1;
          w_beat_data[w*OUTWIDTH +: OUTWIDTH]  = w_src_data[i*OUTWIDTH +: OUTWIDTH];
          w_beat_be[w*BPL +: BPL]              = w_src_mask[i*BPL +: BPL];
        end
      end
    end
  end

  assign w_rest = w_src_pending & ~w_chosen;
  assign w_load = (r_state == IDLE) ? (w_in_hs && (|bus.in_en))
                                    : (w_out_hs && !r_out_last);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:  if (w_in_hs && (|bus.in_en)) w_state_nxt = ISSUE;
      ISSUE: if (w_out_hs && r_out_last)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready   = (r_state == IDLE);
    bus.out_valid  = r_out_valid;
    bus.out_data   = r_out_data;
    bus.out_byteen = r_out_byteen;
    bus.out_last   = r_out_last;
  end

  // r_pending holds lanes not yet placed in any registered beat.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_data       <= '0;
      r_sel        <= '0;
      r_mask       <= '0;
      r_pending    <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_byteen <= '0;
      r_out_last   <= 1'b0;
    end else begin
      if (w_in_hs) begin
        r_data <= bus.in_data;
        r_sel  <= bus.in_sel;
        r_mask <= bus.in_bytemask;
      end
      if (w_load) begin
        r_out_valid  <= 1'b1;
        r_out_data   <= w_beat_data;
        r_out_byteen <= w_beat_be;
        r_out_last   <= ~|w_rest;
        r_pending    <= w_rest;
      end else if (w_out_hs) begin
        r_out_valid  <= 1'b0;
        r_out_data   <= '0;
        r_out_byteen <= '0;
        r_out_last   <= 1'b0;
        r_pending    <= '0;
      end
    end
  end
endmodule

// File: tb/tb_vmem_store_crossbar_128_7_8_32_5.sv
// Scoreboard bench for the vector store crossbar: a lane-order beat model
// feeds a queue that is popped on every accepted output beat.
module tb_vmem_store_crossbar_128_7_8_32_5;
  localparam int unsigned INW = 128;
  localparam int unsigned NL  = 8;
  localparam int unsigned OW  = 32;
  localparam int unsigned SW  = 2;

  typedef struct packed {
    logic [127:0] d;
    logic [15:0]  be;
    logic         last;
  } beat_t;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  vmem_store_crossbar_128_7_8_32_5_if #(
    .INWIDTH(INW), .NUMLANES(NL), .OUTWIDTH(OW), .SELWIDTH(SW)
  ) sif ();

  vmem_store_crossbar_128_7_8_32_5 #(
    .INWIDTH(128), .LOGINWIDTH(7), .NUMLANES(8), .OUTWIDTH(32), .LOGOUTWIDTH(5)
  ) u_dut (
    .clk(clk),
    .resetn(resetn),
    .bus(sif)
  );

  int    total = 0;
  int    bad   = 0;
  beat_t q[$];
  beat_t mb;
  bit    ready_auto = 1'b1;
  bit    ready_rand = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Beat k of a request carries, for each word, the k-th enabled lane targeting it.
  function automatic void push_model(input logic [255:0] d, input logic [15:0] s,
                                     input logic [7:0] e, input logic [31:0] m);
    logic [127:0] bd [8];
    logic [15:0]  bb [8];
    int           cnt [4];
    int           nb;
    int           w, k;
    beat_t        b;
    nb = 0;
    for (int i = 0; i < 8; i++) begin bd[i] = '0; bb[i] = '0; end
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) begin
        w = int'(s[2*i +: 2]);
        k = cnt[w];
        bd[k][w*32 +: 32] = d[i*32 +: 32];
        bb[k][w*4 +: 4]   = m[i*4 +: 4];
        cnt[w]++;
        if (cnt[w] > nb) nb = cnt[w];
      end
    end
    for (int i = 0; i < nb; i++) begin
      b.d = bd[i]; b.be = bb[i]; b.last = (i == nb - 1);
      q.push_back(b);
    end
  endfunction

  logic         stall_prev = 1'b0;
  logic [127:0] p_d;
  logic [15:0]  p_be;
  logic         p_last;

  always @(negedge clk) begin
    if (!resetn) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", 128'(sif.out_valid), 128'(1));
        check("hold_data", sif.out_data, p_d);
        check("hold_be", 128'(sif.out_byteen), 128'(p_be));
        check("hold_last", 128'(sif.out_last), 128'(p_last));
      end
      if (sif.out_valid) begin
        if (q.size() == 0) begin
          check("spurious_beat", 128'(sif.out_valid), 128'(0));
        end else if (sif.out_ready) begin
          mb = q.pop_front();
          check("beat_data", sif.out_data, mb.d);
          check("beat_be", 128'(sif.out_byteen), 128'(mb.be));
          check("beat_last", 128'(sif.out_last), 128'(mb.last));
        end
      end
      stall_prev = sif.out_valid && !sif.out_ready;
      p_d    = sif.out_data;
      p_be   = sif.out_byteen;
      p_last = sif.out_last;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_auto) sif.out_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send(input logic [255:0] d, input logic [15:0] s,
                      input logic [7:0] e, input logic [31:0] m);
    int guard;
    bit hs;
    guard = 0;
    hs    = 1'b0;
    @(posedge clk);
    #1;
    sif.in_valid    = 1'b1;
    sif.in_data     = d;
    sif.in_sel      = s;
    sif.in_en       = e;
    sif.in_bytemask = m;
    while (!hs && guard < 200) begin
      @(negedge clk);
      if (sif.in_ready) hs = 1'b1;
      else guard++;
    end
    check("req_accept", 128'(hs), 128'(1));
    if (hs) push_model(d, s, e, m);
    @(posedge clk);
    #1;
    sif.in_valid = 1'b0;
    @(negedge clk);
    check("lat_valid", 128'(sif.out_valid), 128'(e != 8'h00));
    check("lat_ready", 128'(sif.in_ready), 128'(e == 8'h00));
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (q.size() != 0 && guard < 500) begin
      @(posedge clk);
      guard++;
    end
    check("drain", 128'(q.size() == 0), 128'(1));
    @(negedge clk);
    check("idle_ready", 128'(sif.in_ready), 128'(1));
    check("idle_valid", 128'(sif.out_valid), 128'(0));
  endtask

  logic [255:0] d1, d8, dr;
  logic [15:0]  sr;
  logic [31:0]  mr;
  int           guard;

  initial begin
    sif.in_valid    = 1'b0;
    sif.in_data     = '0;
    sif.in_sel      = '0;
    sif.in_en       = '0;
    sif.in_bytemask = '0;
    sif.out_ready   = 1'b1;

    d1 = {128'h0, 128'h44444444_33333333_22222222_11111111};
    d8 = '0;
    for (int i = 0; i < 8; i++) d8[i*32 +: 32] = 32'(i);

    repeat (2) @(negedge clk);
    check("rst_valid", 128'(sif.out_valid), 128'(0));
    check("rst_ready", 128'(sif.in_ready), 128'(1));
    check("rst_data", sif.out_data, 128'(0));
    check("rst_be", 128'(sif.out_byteen), 128'(0));
    check("rst_last", 128'(sif.out_last), 128'(0));
    resetn = 1'b1;

    // One beat, four distinct words, held so the exact line can be inspected.
    ready_auto = 1'b0;
    sif.out_ready = 1'b0;
    send(d1, 16'h00E4, 8'h0F, 32'h0000_FFFF);
    check("t1_data", sif.out_data, 128'h44444444_33333333_22222222_11111111);
    check("t1_be", 128'(sif.out_byteen), 128'(16'hFFFF));
    check("t1_last", 128'(sif.out_last), 128'(1));
    @(posedge clk); #1;
    sif.out_ready = 1'b1;
    ready_auto = 1'b1;
    drain();

    // All lanes on word 0: eight serial beats.
    send(d8, 16'h0000, 8'hFF, 32'hFFFF_FFFF);
    drain();

    // Empty enable mask is consumed silently, then a normal request follows.
    send(d8, 16'h0000, 8'h00, 32'hFFFF_FFFF);
    ready_rand = 1'b1;
    send(d1, 16'h00E4, 8'h0F, 32'h0000_FFFF);
    drain();
    ready_rand = 1'b0;

    // Lanes 0 and 5 collide on word 2; first beat stalled by the cache.
    ready_auto = 1'b0;
    sif.out_ready = 1'b0;
    dr = '0;
    dr[0*32 +: 32] = 32'hA0A0A0A0;
    dr[1*32 +: 32] = 32'hB1B1B1B1;
    dr[5*32 +: 32] = 32'hC5C5C5C5;
    sr = '0;
    sr[0*2 +: 2] = 2'd2;
    sr[1*2 +: 2] = 2'd0;
    sr[5*2 +: 2] = 2'd2;
    send(dr, sr, 8'b0010_0011, 32'hFFFF_FFFF);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t4_data", sif.out_data, 128'h00000000_A0A0A0A0_00000000_B1B1B1B1);
      check("t4_be", 128'(sif.out_byteen), 128'(16'h0F0F));
      check("t4_last", 128'(sif.out_last), 128'(0));
    end
    @(posedge clk); #1;
    sif.out_ready = 1'b1;
    ready_auto = 1'b1;
    drain();

    // Single lane on the top word with a sparse byte mask.
    ready_auto = 1'b0;
    sif.out_ready = 1'b0;
    dr = '0;
    dr[2*32 +: 32] = 32'hAABBCCDD;
    send(dr, 16'h0030, 8'h04, 32'h0000_0500);
    check("t5_data", sif.out_data, 128'hAABBCCDD_00000000_00000000_00000000);
    check("t5_be", 128'(sif.out_byteen), 128'(16'h5000));
    check("t5_last", 128'(sif.out_last), 128'(1));
    @(posedge clk); #1;
    sif.out_ready = 1'b1;
    ready_auto = 1'b1;
    drain();

    // Reset while the second of eight beats is on the bus.
    send(d8, 16'h0000, 8'hFF, 32'hFFFF_FFFF);
    guard = 0;
    do begin
      @(posedge clk);
      guard++;
    end while (q.size() > 7 && guard < 50);
    check("t6_beat1_seen", 128'(q.size() == 7), 128'(1));
    #2;
    resetn = 1'b0;
    #1;
    check("t6_rst_valid", 128'(sif.out_valid), 128'(0));
    check("t6_rst_ready", 128'(sif.in_ready), 128'(1));
    q.delete();
    @(negedge clk);
    resetn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t6_quiet_valid", 128'(sif.out_valid), 128'(0));
      check("t6_quiet_ready", 128'(sif.in_ready), 128'(1));
    end
    send(d1, 16'h00E4, 8'h0F, 32'h0000_FFFF);
    drain();

    // Random requests with random cache back-pressure.
    ready_rand = 1'b1;
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < 8; i++) dr[i*32 +: 32] = $urandom;
      sr = 16'($urandom);
      mr = $urandom;
      send(dr, sr, 8'($urandom), mr);
    end
    drain();
    ready_rand = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/vmem_store_crossbar_128_7_8_32_5.md
Name: vmem_store_crossbar_128_7_8_32_5

Overview:
Write-direction counterpart of the vector memory load crossbar.
- Accepts one store request of NUMLANES lanes, each OUTWIDTH bits wide, with a per-lane word select, lane enable and byte mask.
- Steers the lane data into INWIDTH-bit memory-line beats with byte enables for the data-cache write port.
- When several enabled lanes target the same word, it serialises them over multiple beats, resolving conflicts in lane order.

Parameters:
- INWIDTH, 128, memory line width in bits.
- LOGINWIDTH, 7, log2(INWIDTH).
- NUMLANES, 8, number of vector lanes.
- OUTWIDTH, 32, lane data width in bits.
- LOGOUTWIDTH, 5, log2(OUTWIDTH).
- SELWIDTH, LOGINWIDTH-LOGOUTWIDTH (=2), derived; word-select width per lane.
- NUMWORDS, INWIDTH/OUTWIDTH (=4), derived; words per line.

Ports:
- clk, input, 1, clock.
- resetn, input, 1, asynchronous active-low reset.
- in_valid, input, 1, store request valid.
- in_ready, output, 1, block can accept a request.
- in_data, input, OUTWIDTH*NUMLANES, lane i data at [(i+1)*OUTWIDTH-1 : i*OUTWIDTH].
- in_sel, input, SELWIDTH*NUMLANES, lane i target word index.
- in_en, input, NUMLANES, lane enable.
- in_bytemask, input, (OUTWIDTH/8)*NUMLANES, lane i byte mask (4 bits per lane).
- out_valid, output, 1, line beat valid.
- out_ready, input, 1, cache write port accepts beat.
- out_data, output, INWIDTH, line data; word w at [(w+1)*OUTWIDTH-1 : w*OUTWIDTH].
- out_byteen, output, INWIDTH/8, byte enables.
- out_last, output, 1, final beat of the current request.

Behaviour:
- Reset (asynchronous, resetn=0):
  - State returns to IDLE; pending lane mask cleared.
  - out_valid=0, out_data=0, out_byteen=0, out_last=0, in_ready=1.
  - Reset mid-request drops all remaining beats; no partial beat is emitted after reset deasserts.
- States: IDLE, ISSUE.
- in_ready=1 only in IDLE. Handshake is in_valid & in_ready.
- IDLE, on handshake:
  - Latch data, sel and bytemask; set pending = in_en.
  - If in_en==0: request is consumed and dropped, state stays IDLE, no beat emitted.
  - Otherwise: go to ISSUE and register the first beat. out_valid=1 in the cycle after the handshake (latency 1).
- Beat formation, from the current pending mask, for each word w:
  - Choose the lowest-numbered pending lane i with sel_i==w.
  - Word w of out_data = data_i; bytes of word w in out_byteen = bytemask_i.
  - Words with no chosen lane get data 0 and byteen 0.
  - out_last=1 iff no pending lanes remain after removing this beat's chosen lanes.
- ISSUE:
  - out_* are registered and held stable while out_valid & ~out_ready.
  - On out handshake, clear the chosen lanes from pending.
  - If out_last was 1: go to IDLE and drop out_valid next cycle. in_ready=1 from that cycle.
  - Otherwise: register the next beat, which appears the cycle after the handshake. out_valid stays 1 with no bubble.
- Beat count = max over w of the number of enabled lanes with sel==w; range 1..NUMLANES.
- An enabled lane with bytemask==0 still occupies its word slot in its beat and contributes byteen 0.
- Minimum request-to-request spacing is beats+1 cycles, which includes the IDLE acceptance cycle.
- Width rules:
  - in_sel is unsigned and every value 0..NUMWORDS-1 is valid.
  - out_byteen bit b of word w = byte (w*4+b), little-endian within the word.

Test Plan:
- Lanes 0-3 enabled, sel=0,1,2,3, data=0x11111111..0x44444444, bytemask=0xF -> one beat: out_data=0x44444444_33333333_22222222_11111111, out_byteen=0xFFFF, out_last=1, out_valid the cycle after the handshake.
- All 8 lanes enabled, sel=0, data=lane index -> 8 consecutive beats: out_data[31:0]=0..7 in order, out_byteen=0x000F each, out_last only on beat 8, in_ready=1 the cycle after beat 8 is accepted.
- in_en=0x00 -> request accepted, no out_valid ever, in_ready=1 the next cycle; a second request then issues normally.
- Lanes 0 and 5 both sel=2, lane 1 sel=0, out_ready held 0 for 3 cycles -> beat 1: word2=lane0, word0=lane1, byteen=0x0F0F, held stable for 3 cycles. Beat 2: word2=lane5, byteen=0x0F00, out_last=1.
- Lane 2 only, sel=3, bytemask=0x5, data=0xAABBCCDD -> out_data=0xAABBCCDD<<96, out_byteen=0x5000.
- resetn pulsed low during beat 2 of the 8-beat case -> out_valid=0 immediately; after release in_ready=1, no further beats; a new request issues normally.
